// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator.
// Operands are captured on a valid/ready handshake and scanned MSB-first, DIGIT bits
// per cycle, stopping at the first differing digit. Signed compares invert the sign
// bit of both operands at capture (offset binary), so the scan itself is always unsigned.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 2,
    localparam int unsigned NDIG = WIDTH / DIGIT,
    localparam int unsigned CW   = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    assign dig_a = sh_a_q[WIDTH-1 -: DIGIT];
    assign dig_b = sh_b_q[WIDTH-1 -: DIGIT];

    // Handshake outputs decode directly from state; in_ready is held low during reset.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign cycles    = cycles_q;

    // Next-state: capture, per-digit scan with early exit, result hold.
    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cnt_d    = cnt_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        cycles_d = cycles_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sh_a_d = a;
                    sh_b_d = b;
                    // Offset-binary: flipping both sign bits makes unsigned order match signed.
                    if (signed_mode) begin
                        sh_a_d[WIDTH-1] = ~a[WIDTH-1];
                        sh_b_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    cnt_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (dig_a > dig_b) begin
                    gt_d     = 1'b1;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = StDone;
                end else if (dig_a < dig_b) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b1;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = StDone;
                end else if (cnt_q == CW'(NDIG - 1)) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b1;
                    lt_d     = 1'b0;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = StDone;
                end else begin
                    sh_a_d = sh_a_q << DIGIT;
                    sh_b_d = sh_b_q << DIGIT;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            cnt_q    <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            cnt_q    <= cnt_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            cycles_q <= cycles_d;
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=16, DIGIT=2).
module tb_serial_magnitude_comparator;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 2;
    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CW    = $clog2(NDIG + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [CW-1:0]    cycles;

    int n_cmp = 0;
    int n_err = 0;

    serial_magnitude_comparator #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 1-based index of the first differing digit; sign-bit flipping in
    // signed mode hits both operands, so it never changes where they differ.
    function automatic int ref_cycles(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (((d >> (WIDTH - DIGIT * (i + 1))) & ((1 << DIGIT) - 1)) != 0) return i + 1;
        end
        return NDIG;
    endfunction

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_val, input logic sm, input int stall);
        int  guard;
        int  k;
        int  exp_cyc;
        logic exp_gt, exp_eq, exp_lt;
        if (sm) begin
            exp_gt = $signed(ta) > $signed(tb_val);
            exp_lt = $signed(ta) < $signed(tb_val);
        end else begin
            exp_gt = ta > tb_val;
            exp_lt = ta < tb_val;
        end
        exp_eq  = (ta == tb_val);
        exp_cyc = ref_cycles(ta, tb_val);

        in_valid    = 1'b1;
        a           = ta;
        b           = tb_val;
        signed_mode = sm;
        guard       = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        // Garbage on the idle inputs must not disturb the scan.
        in_valid    = 1'b0;
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        k = 0;
        while (!out_valid && k < int'(NDIG) + 4) begin
            check({tag, "_scan_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_cyc));
        check({tag, "_result"}, {29'd0, gt, eq, lt}, {29'd0, exp_gt, exp_eq, exp_lt});
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_cyc));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_stall_hold"}, {26'd0, out_valid, in_ready, gt, eq, lt, 1'b0},
                  {26'd0, 1'b1, 1'b0, exp_gt, exp_eq, exp_lt, 1'b0});
            check({tag, "_stall_cycles"}, 32'(cycles), 32'(exp_cyc));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_hs"}, {27'd0, out_valid, in_ready, gt, eq, lt},
              {27'd0, 1'b0, 1'b1, exp_gt, exp_eq, exp_lt});
        check({tag, "_post_cycles"}, 32'(cycles), 32'(exp_cyc));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               sel;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_outputs", {27'd0, out_valid, gt, eq, lt, 1'b0}, 32'd0);
        check("reset_cycles", 32'(cycles), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op("msb_diff", 16'h8000, 16'h7FFF, 1'b0, 0);
        run_op("equal", 16'h1234, 16'h1234, 1'b0, 1);
        run_op("lsb_lt", 16'h0001, 16'h0002, 1'b0, 0);
        run_op("signed_neg", 16'hFFFF, 16'h0001, 1'b1, 0);
        run_op("unsigned_big", 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op("stall5", 16'h00F0, 16'h00E0, 1'b0, 5);
        run_op("signed_minmax", 16'h8000, 16'h7FFF, 1'b1, 2);

        // Reset in the middle of a long (equal-operand) scan
        in_valid = 1'b1;
        a        = 16'h5555;
        b        = 16'h5555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midscan_rst_out", {27'd0, out_valid, gt, eq, lt, in_ready}, 32'd0);
        check("midscan_rst_cycles", 32'(cycles), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midscan_rst_hold", {27'd0, out_valid, gt, eq, lt, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        run_op("after_rst_eq", 16'h0010, 16'h0010, 1'b0, 0);

        // Randomized operations with stalls, biased towards long shared prefixes
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 3));
            ra  = WIDTH'($urandom);
            case (sel)
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = ra ^ WIDTH'($urandom_range(0, 15));
            endcase
            run_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
